decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 64: datapath width; register values, PC and immediates.
REQ-002 SHALL have parameter NREGS, default 32: architectural register count, 2..32; register addresses are fixed 5-bit.
REQ-003 SHALL have parameter CNTW, default 32: bubble-counter width.
REQ-004 SHALL have the following ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock; all state on rising edge
  rst  in  1  asynchronous, active-high reset
  if_valid  in  1  IF/ID holds a valid instruction
  ir_in  in  32  instruction word (RV32/64 base encoding)
  pc_in  in  XLEN  instruction PC
  id_ready  out  1  decode consumes ir_in this cycle
  ex_ready  in  1  EX accepts the ID/EX register contents this cycle
  flush  in  1  kill the incoming instruction and the ID/EX contents
  wb_we  in  1  register-file write enable
  wb_addr  in  5  write address
  wb_data  in  XLEN  write data
  id_valid  out  1  ID/EX holds a valid instruction
  rs1_val, rs2_val  out  XLEN  each: source operand values
  imm_out  out  XLEN  sign-extended immediate
  pc_out  out  XLEN  registered PC
  rs1_out, rs2_out, rd_out  out  5  each: register fields
  opcode_out  out  7  ir[6:0]
  funct3_out  out  3  ir[14:12]
  funct7b5_out  out  1  ir[30]
  bubble_cnt  out  CNTW  number of load-use bubbles inserted

Function
REQ-005 SHALL extract fields as follows: rs1=ir[19:15]; rs2=ir[24:20]; rd=ir[11:7].
REQ-006 SHALL hold NREGS registers; x0 SHALL read as 0, and writes to x0 SHALL be ignored; an address >= NREGS SHALL read as 0 and its writes SHALL be ignored.
REQ-007 SHALL perform the RF write on the rising clk edge when wb_we=1.
REQ-008 SHALL perform RF reads combinationally with write-through bypass: if wb_we=1, wb_addr equals the read address and the read address is non-zero, the read returns wb_data.
REQ-009 SHALL generate the immediate by opcode, sign-extended from bit 31 to XLEN:
  I-type (0010011, 0000011, 1100111)
  S-type (0100011)
  B-type (1100011, bit0=0)
  U-type (0110111, 0010111; bits[11:0]=0)
  J-type (1101111, bit0=0)
  all other opcodes: imm=0
REQ-010 SHALL treat rs1 as used for all opcodes except U and J, and rs2 as used for opcodes 0110011, 0100011 and 1100011.
REQ-011 SHALL raise hazard=1 when all of the following hold:
  if_valid=1
  id_valid=1
  opcode_out=0000011
  rd_out != 0
  rd_out equals a used rs1 or a used rs2 of ir_in
REQ-012 SHALL drive id_ready = flush | (ex_ready & ~hazard), combinationally.
REQ-013 SHALL update the ID/EX register on each edge with the following priority:
  (a) flush=1: id_valid<=0; other fields don't-care, but held.
  (b) ex_ready=0: hold all outputs unchanged.
  (c) hazard=1: id_valid<=0 (bubble); bubble_cnt increments.
  (d) otherwise: id_valid<=if_valid; capture all fields, operand values, imm and pc.
REQ-014 SHALL let bubble_cnt saturate at all-ones; it SHALL NOT increment on flush or on an ex_ready=0 cycle.
REQ-015 SHALL make ID/EX latency exactly one cycle: an instruction accepted at edge N appears on the outputs after edge N.
REQ-016 SHALL NOT forward load data (that belongs to the EX stage); the one-cycle bubble alone resolves load-use.
REQ-017 SHALL capture a WB write occurring in the same cycle as a decode through the REQ-008 bypass.

Reset
REQ-018 SHALL, while rst=1 and independent of clk, immediately drive all of the following to 0: id_valid, every registered output, bubble_cnt and all RF entries.
REQ-019 SHALL leave id_ready combinational during reset, per REQ-012.
REQ-020 SHALL accept the first instruction on the first rising edge after rst deasserts.

Verification
REQ-021 Basic decode: after reset, ir_in=0xFFF00093 (addi x1,x0,-1), if_valid=1, ex_ready=1 -> after the next edge: id_valid=1, rd_out=1, rs1_val=0, imm_out=0xFFFF_FFFF_FFFF_FFFF.
REQ-022 Write-through bypass: wb_we=1, wb_addr=5, wb_data=0x1234 in the same cycle as ir_in with rs1=5 -> rs1_val=0x1234. Then write wb_addr=0 with 0xFF and read x0 -> 0.
REQ-023 Load-use: accept 0x00013183 (ld x3,0(x2)), then present 0x00118233 (add x4,x3,x1) -> id_ready=0 for one cycle, id_valid=0 for one cycle, bubble_cnt=1; the add is captured on the following edge.
REQ-024 Backpressure: ex_ready=0 for 3 cycles -> all outputs stable, id_ready=0, bubble_cnt unchanged.
REQ-025 Flush during a hazard: repeat the REQ-023 setup and assert flush on the hazard cycle -> id_ready=1, id_valid=0 after the edge, bubble_cnt not incremented.
REQ-026 Asynchronous reset: assert rst mid-cycle with id_valid=1 -> id_valid, outputs and bubble_cnt read 0 before the next edge; RF reads return 0.

Source files
------------

// File: rtl/decode_pipe.sv
// Decode stage: register file with write-through bypass, immediate generation,
// load-use hazard detection and the ID/EX pipeline register.
module decode_pipe #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREGS = 32,
    parameter int unsigned CNTW  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     ir_in,
    input  logic [XLEN-1:0] pc_in,
    output logic            id_ready,
    input  logic            ex_ready,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            id_valid,
    output logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] rs2_val,
    output logic [XLEN-1:0] imm_out,
    output logic [XLEN-1:0] pc_out,
    output logic [4:0]      rs1_out,
    output logic [4:0]      rs2_out,
    output logic [4:0]      rd_out,
    output logic [6:0]      opcode_out,
    output logic [2:0]      funct3_out,
    output logic            funct7b5_out,
    output logic [CNTW-1:0] bubble_cnt
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpReg    = 7'b0110011;

    // x0 is never stored; entries 1..NREGS-1 only
    logic [XLEN-1:0] rf_q [1:NREGS-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < int'(NREGS); i++) rf_q[i] <= '0;
        end else if (wb_we) begin
            for (int i = 1; i < int'(NREGS); i++) begin
                if (wb_addr == 5'(i)) rf_q[i] <= wb_data;
            end
        end
    end

    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] addr);
        logic [XLEN-1:0] val;
        val = '0;
        for (int i = 1; i < int'(NREGS); i++) begin
            if (addr == 5'(i)) val = (wb_we && wb_addr == addr) ? wb_data : rf_q[i];
        end
        return val;
    endfunction

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] imm_d;
    logic            rs1_used, rs2_used, hazard, capture;
    logic            valid_d, valid_q;
    logic [CNTW-1:0] cnt_d, cnt_q;

    assign opcode = ir_in[6:0];
    assign rs1    = ir_in[19:15];
    assign rs2    = ir_in[24:20];
    assign rd     = ir_in[11:7];

    always_comb begin
        imm_d = '0;
        case (opcode)
            OpImm, OpLoad, OpJalr: imm_d = XLEN'($signed(ir_in[31:20]));
            OpStore:  imm_d = XLEN'($signed({ir_in[31:25], ir_in[11:7]}));
            OpBranch: imm_d = XLEN'($signed({ir_in[31], ir_in[7], ir_in[30:25],
                                             ir_in[11:8], 1'b0}));
            OpLui, OpAuipc: imm_d = XLEN'($signed({ir_in[31:12], 12'b0}));
            OpJal:    imm_d = XLEN'($signed({ir_in[31], ir_in[19:12], ir_in[20],
                                             ir_in[30:21], 1'b0}));
            default:  imm_d = '0;
        endcase
    end

    always_comb begin
        rs1_used = !(opcode == OpLui || opcode == OpAuipc || opcode == OpJal);
        rs2_used = (opcode == OpReg || opcode == OpStore || opcode == OpBranch);
        hazard   = if_valid && valid_q && opcode_out == OpLoad && rd_out != 5'd0 &&
                   ((rs1_used && rs1 == rd_out) || (rs2_used && rs2 == rd_out));
        id_ready = flush | (ex_ready & ~hazard);
        capture  = ~flush & ex_ready & ~hazard;

        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (ex_ready) begin
            valid_d = hazard ? 1'b0 : if_valid;
            if (hazard && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            cnt_q        <= '0;
            rs1_val      <= '0;
            rs2_val      <= '0;
            imm_out      <= '0;
            pc_out       <= '0;
            rs1_out      <= '0;
            rs2_out      <= '0;
            rd_out       <= '0;
            opcode_out   <= '0;
            funct3_out   <= '0;
            funct7b5_out <= 1'b0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                rs1_val      <= rf_read(rs1);
                rs2_val      <= rf_read(rs2);
                imm_out      <= imm_d;
                pc_out       <= pc_in;
                rs1_out      <= rs1;
                rs2_out      <= rs2;
                rd_out       <= rd;
                opcode_out   <= opcode;
                funct3_out   <= ir_in[14:12];
                funct7b5_out <= ir_in[30];
            end
        end
    end

    assign id_valid   = valid_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe: directed scenarios plus randomized
// traffic compared against an instruction-level reference model.
module tb_decode_pipe;

    localparam int XL = 64;
    localparam int CW = 4;

    logic          clk, rst, if_valid, ex_ready, flush, wb_we;
    logic [31:0]   ir_in;
    logic [XL-1:0] pc_in, wb_data;
    logic [4:0]    wb_addr;
    logic          id_ready, id_valid, funct7b5_out;
    logic [XL-1:0] rs1_val, rs2_val, imm_out, pc_out;
    logic [4:0]    rs1_out, rs2_out, rd_out;
    logic [6:0]    opcode_out;
    logic [2:0]    funct3_out;
    logic [CW-1:0] bubble_cnt;

    decode_pipe #(.XLEN(XL), .NREGS(32), .CNTW(CW)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .ir_in(ir_in), .pc_in(pc_in),
        .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush), .wb_we(wb_we),
        .wb_addr(wb_addr), .wb_data(wb_data), .id_valid(id_valid), .rs1_val(rs1_val),
        .rs2_val(rs2_val), .imm_out(imm_out), .pc_out(pc_out), .rs1_out(rs1_out),
        .rs2_out(rs2_out), .rd_out(rd_out), .opcode_out(opcode_out),
        .funct3_out(funct3_out), .funct7b5_out(funct7b5_out), .bubble_cnt(bubble_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: architectural registers and the instruction held in ID/EX
    logic [XL-1:0] rf_m [32];
    logic          m_valid;
    logic [31:0]   m_ir;
    logic [XL-1:0] m_pc, m_r1, m_r2;
    int unsigned   m_cnt;
    int            n_tests, n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] imm_of(input logic [31:0] ir);
        logic [63:0] v;
        v = 64'd0;
        case (ir[6:0])
            7'h13, 7'h03, 7'h67: begin
                v = 64'(ir[31:20]);
                if (ir[31]) v = v - 64'd4096;
            end
            7'h23: begin
                v = 64'({ir[31:25], ir[11:7]});
                if (ir[31]) v = v - 64'd4096;
            end
            7'h63: begin
                v = 64'(ir[11:8]) * 2 + 64'(ir[30:25]) * 32 + 64'(ir[7]) * 2048;
                if (ir[31]) v = v - 64'd4096;
            end
            7'h37, 7'h17: begin
                v = 64'(ir[31:12]) * 4096;
                if (ir[31]) v = v - 64'h1_0000_0000;
            end
            7'h6F: begin
                v = 64'(ir[30:21]) * 2 + 64'(ir[20]) * 2048 + 64'(ir[19:12]) * 4096;
                if (ir[31]) v = v - 64'h10_0000;
            end
            default: v = 64'd0;
        endcase
        return v;
    endfunction

    function automatic bit uses1(input logic [6:0] op);
        return !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    endfunction

    function automatic bit uses2(input logic [6:0] op);
        return (op == 7'h33 || op == 7'h23 || op == 7'h63);
    endfunction

    function automatic logic [63:0] rd_m(input logic [4:0] a);
        if (a == 5'd0) return 64'd0;
        if (wb_we && wb_addr == a) return wb_data;
        return rf_m[a];
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 32; i++) rf_m[i] = '0;
        m_valid = 1'b0; m_ir = '0; m_pc = '0; m_r1 = '0; m_r2 = '0; m_cnt = 0;
    endtask

    task automatic check_outputs();
        check("id_valid", 64'(id_valid), 64'(m_valid));
        check("bubble_cnt", 64'(bubble_cnt), 64'(m_cnt));
        if (m_valid) begin
            check("rd_out", 64'(rd_out), 64'(m_ir[11:7]));
            check("rs1_out", 64'(rs1_out), 64'(m_ir[19:15]));
            check("rs2_out", 64'(rs2_out), 64'(m_ir[24:20]));
            check("opcode_out", 64'(opcode_out), 64'(m_ir[6:0]));
            check("funct3_out", 64'(funct3_out), 64'(m_ir[14:12]));
            check("funct7b5_out", 64'(funct7b5_out), 64'(m_ir[30]));
            check("imm_out", imm_out, imm_of(m_ir));
            check("pc_out", pc_out, m_pc);
            check("rs1_val", rs1_val, m_r1);
            check("rs2_val", rs2_val, m_r2);
        end
    endtask

    // Inputs must be set before calling; checks id_ready, advances one edge, checks outputs
    task automatic step();
        bit haz;
        logic [6:0] mop;
        #2;
        mop = m_ir[6:0];
        haz = if_valid && m_valid && mop == 7'h03 && m_ir[11:7] != 5'd0 &&
              ((uses1(ir_in[6:0]) && ir_in[19:15] == m_ir[11:7]) ||
               (uses2(ir_in[6:0]) && ir_in[24:20] == m_ir[11:7]));
        check("id_ready", 64'(id_ready), 64'(flush | (ex_ready & ~haz)));
        if (flush) begin
            m_valid = 1'b0;
        end else if (ex_ready) begin
            if (haz) begin
                m_valid = 1'b0;
                if (m_cnt < (1 << CW) - 1) m_cnt++;
            end else begin
                m_valid = if_valid;
                m_ir    = ir_in;
                m_pc    = pc_in;
                m_r1    = rd_m(ir_in[19:15]);
                m_r2    = rd_m(ir_in[24:20]);
            end
        end
        if (wb_we && wb_addr != 5'd0) rf_m[wb_addr] = wb_data;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    logic [6:0] ops [10];

    initial begin
        ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0B};
        n_tests = 0; n_fail = 0;
        reset_model();
        rst = 1'b1; if_valid = 1'b0; ir_in = '0; pc_in = '0; ex_ready = 1'b1;
        flush = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        #12;
        check("rst_id_valid", 64'(id_valid), 64'd0);
        check("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
        check("rst_imm_out", imm_out, 64'd0);
        check("rst_pc_out", pc_out, 64'd0);
        check("rst_rd_out", 64'(rd_out), 64'd0);
        check("rst_id_ready", 64'(id_ready), 64'd1);
        rst = 1'b0;

        // addi x1,x0,-1
        ir_in = 32'hFFF00093; if_valid = 1'b1; pc_in = 64'h1000;
        step();
        check("basic_rd", 64'(rd_out), 64'd1);
        check("basic_imm", imm_out, 64'hFFFF_FFFF_FFFF_FFFF);
        check("basic_rs1_val", rs1_val, 64'd0);

        // write-through: addi x6,x5,0 while writing x5
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 64'h1234; ir_in = 32'h0002_8313;
        pc_in = 64'h1004;
        step();
        check("bypass_rs1_val", rs1_val, 64'h1234);
        wb_addr = 5'd0; wb_data = 64'hFF; ir_in = 32'h0000_0313;
        step();
        check("x0_bypass", rs1_val, 64'd0);
        wb_we = 1'b0;
        step();
        check("x0_read", rs1_val, 64'd0);

        // load-use: ld x3,0(x2) then add x4,x3,x1
        ir_in = 32'h0001_3183; pc_in = 64'h1008;
        step();
        ir_in = 32'h0011_8233; pc_in = 64'h100C;
        step();
        check("loaduse_valid", 64'(id_valid), 64'd0);
        check("loaduse_cnt", 64'(bubble_cnt), 64'd1);
        step();
        check("loaduse_add_rd", 64'(rd_out), 64'd4);

        // backpressure
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ir_in = 32'h0000_0093 | 32'($urandom_range(0, 31) << 15);
            pc_in = 64'h2000 + 64'(i);
            step();
            check("bp_id_ready", 64'(id_ready), 64'd0);
            check("bp_pc_hold", pc_out, 64'h100C);
        end
        ex_ready = 1'b1;

        // flush on the hazard cycle
        ir_in = 32'h0001_3183; pc_in = 64'h3000;
        step();
        ir_in = 32'h0011_8233; flush = 1'b1; pc_in = 64'h3004;
        #2;
        check("flush_id_ready", 64'(id_ready), 64'd1);
        #(-0) step();
        check("flush_valid", 64'(id_valid), 64'd0);
        check("flush_cnt", 64'(bubble_cnt), 64'd1);
        flush = 1'b0;

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            ir_in = $urandom;
            ir_in[6:0] = ops[$urandom_range(0, 9)];
            ir_in[11:7] = 5'($urandom_range(0, 7));
            ir_in[19:15] = 5'($urandom_range(0, 7));
            ir_in[24:20] = 5'($urandom_range(0, 7));
            pc_in = {32'($urandom), 32'($urandom)};
            if_valid = ($urandom_range(0, 7) != 0);
            ex_ready = ($urandom_range(0, 5) != 0);
            flush = ($urandom_range(0, 15) == 0);
            wb_we = ($urandom_range(0, 1) != 0);
            wb_addr = 5'($urandom_range(0, 31));
            wb_data = {32'($urandom), 32'($urandom)};
            step();
        end

        // asynchronous reset mid-cycle with a valid instruction held
        flush = 1'b0; ex_ready = 1'b1; if_valid = 1'b1; wb_we = 1'b1;
        wb_addr = 5'd5; wb_data = 64'h55AA; ir_in = 32'h0000_0293;
        step();
        wb_we = 1'b0;
        step();
        check("pre_rst_valid", 64'(id_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        reset_model();
        check("arst_id_valid", 64'(id_valid), 64'd0);
        check("arst_bubble_cnt", 64'(bubble_cnt), 64'd0);
        check("arst_imm_out", imm_out, 64'd0);
        check("arst_pc_out", pc_out, 64'd0);
        check("arst_rd_out", 64'(rd_out), 64'd0);
        rst = 1'b0;
        ir_in = 32'h0002_8313; pc_in = 64'h4000;
        step();
        check("arst_rf_x5", rs1_val, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
